cdu_pulse_sched: RTL and testbench

CDU_PULSE_SCHED -- requirements
Module: cdu_pulse_sched

---
 rtl/cdu_pkg.sv | 15 +
 rtl/cdu_pend_cnt.sv | 41 ++++
 rtl/cdu_pulse_sched.sv | 135 +++++++++++++
 tb/tb_cdu_pulse_sched.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdu_pkg.sv
// Shared types and default sizing for the CDU pulse scheduler.
// Build option: CDU_SCHED_OVF_EN enables the sticky saturation flags.
package cdu_pkg;

   localparam int CDU_NCH   = 5;
   localparam int CDU_CNT_W = 4;
   localparam int CDU_GAP   = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      HOLD  = 2'd2
   } cdu_state_t;

endpackage

// File: rtl/cdu_pend_cnt.sv
// Saturating signed pending-count register for one angle channel.
// Latency: one cycle from inc/dec/adj to value; no backpressure, clip is same-cycle.
// adj is two's complement: 01 = plus pulse issued, 11 = minus pulse issued, 00 = none.
module cdu_pend_cnt #(
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             dec,
   input  logic [1:0]       adj,
   output logic [CNT_W-1:0] value,
   output logic             clip
);

   localparam logic signed [CNT_W+1:0] SUM_MAX = (CNT_W+2)'(2**(CNT_W-1) - 1);
   localparam logic signed [CNT_W+1:0] SUM_MIN = (CNT_W+2)'(-(2**(CNT_W-1)));

   logic signed [2:0]       delta;
   logic signed [CNT_W+1:0] sum;

   // Two guard bits keep the unclipped sum exact for any delta in -3..+3.
   always_comb begin
      delta = $signed({2'b00, inc}) - $signed({2'b00, dec}) - $signed({adj[1], adj});
      sum   = $signed({{2{value[CNT_W-1]}}, value}) + $signed({{(CNT_W-1){delta[2]}}, delta});
      clip  = (sum > SUM_MAX) || (sum < SUM_MIN);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         value <= '0;
      end else if (sum > SUM_MAX) begin
         value <= SUM_MAX[CNT_W-1:0];
      end else if (sum < SUM_MIN) begin
         value <= SUM_MIN[CNT_W-1:0];
      end else begin
         value <= sum[CNT_W-1:0];
      end
   end

endmodule

// File: rtl/cdu_pulse_sched.sv
// Round-robin scheduler turning per-channel +/- angle requests into a single pulse stream.
// Latency: request to out_valid in two cycles when idle; pulses spaced by at least GAP+1 cycles.
// Backpressure: out_valid/out_ch/out_minus hold until out_ready; requests keep counting meanwhile.
// Build option: CDU_SCHED_OVF_EN makes ovf sticky saturation flags, otherwise ovf is tied to 0.
module cdu_pulse_sched
   import cdu_pkg::*;
#(
   parameter int NCH   = CDU_NCH,
   parameter int CNT_W = CDU_CNT_W,
   parameter int GAP   = CDU_GAP
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NCH-1:0]          req_plus,
   input  logic [NCH-1:0]          req_minus,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [$clog2(NCH)-1:0]  out_ch,
   output logic                    out_minus,
   output logic [NCH-1:0]          ovf
);

   localparam int CH_W   = $clog2(NCH);
   localparam int HOLD_W = (GAP > 1) ? $clog2(GAP) : 1;

   cdu_state_t        state;
   logic [CH_W-1:0]   rr_ptr;
   logic [HOLD_W-1:0] hold_cnt;
   logic [CNT_W-1:0]  p   [NCH];
   logic [1:0]        adj [NCH];
   logic [NCH-1:0]    clip;
   logic [NCH-1:0]    nz;
   logic [NCH-1:0]    neg;
   logic              accept;
   logic              gnt_vld;
   logic [CH_W-1:0]   gnt_ch;

   assign accept = out_valid & out_ready;

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      assign adj[i] = (accept && out_ch == CH_W'(i)) ? (out_minus ? 2'b11 : 2'b01) : 2'b00;
      assign nz[i]  = |p[i];
      assign neg[i] = p[i][CNT_W-1];

      cdu_pend_cnt #(.CNT_W(CNT_W)) u_cnt (
         .clk   (clk),
         .rst   (rst),
         .inc   (req_plus[i]),
         .dec   (req_minus[i]),
         .adj   (adj[i]),
         .value (p[i]),
         .clip  (clip[i])
      );
   end

   // Scan from the far end back so the channel nearest rr_ptr wins.
   always_comb begin
      gnt_vld = 1'b0;
      gnt_ch  = '0;
      for (int k = NCH - 1; k >= 0; k--) begin
         int idx;
         idx = (int'(rr_ptr) + k) % NCH;
         if (nz[CH_W'(idx)]) begin
            gnt_vld = 1'b1;
            gnt_ch  = CH_W'(idx);
         end
      end
   end

   // The last HOLD cycle arbitrates directly so a busy stream runs at one pulse per GAP+1 cycles.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         rr_ptr    <= '0;
         hold_cnt  <= '0;
         out_valid <= 1'b0;
         out_ch    <= '0;
         out_minus <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (gnt_vld) begin
                  state     <= ISSUE;
                  out_valid <= 1'b1;
                  out_ch    <= gnt_ch;
                  out_minus <= neg[gnt_ch];
               end
            end
            ISSUE: begin
               if (accept) begin
                  out_valid <= 1'b0;
                  rr_ptr    <= (out_ch == CH_W'(NCH - 1)) ? '0 : out_ch + 1'b1;
                  if (GAP > 0) begin
                     state    <= HOLD;
                     hold_cnt <= HOLD_W'(GAP - 1);
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            HOLD: begin
               if (hold_cnt != '0) begin
                  hold_cnt <= hold_cnt - 1'b1;
               end else if (gnt_vld) begin
                  state     <= ISSUE;
                  out_valid <= 1'b1;
                  out_ch    <= gnt_ch;
                  out_minus <= neg[gnt_ch];
               end else begin
                  state <= IDLE;
               end
            end
            default: begin
               state     <= IDLE;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

`ifdef CDU_SCHED_OVF_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         ovf <= '0;
      end else begin
         ovf <= ovf | clip;
      end
   end
`else
   logic unused_clip;
   assign unused_clip = ^clip;
   assign ovf = '0;
`endif

endmodule

// File: tb/tb_cdu_pulse_sched.sv
// Bench for cdu_pulse_sched: directed scenarios plus random traffic against a timing-rule model.
module tb_cdu_pulse_sched;

   localparam int NCH   = 5;
   localparam int CNT_W = 4;
   localparam int GAP   = 3;
   localparam int PMAX  = 7;
   localparam int PMIN  = -8;
`ifdef CDU_SCHED_OVF_EN
   localparam bit OVF_EN = 1'b1;
`else
   localparam bit OVF_EN = 1'b0;
`endif

   logic           clk = 1'b0;
   logic           rst;
   logic [NCH-1:0] req_plus;
   logic [NCH-1:0] req_minus;
   logic           out_valid;
   logic           out_ready;
   logic [2:0]     out_ch;
   logic           out_minus;
   logic [NCH-1:0] ovf;

   always #5 clk = ~clk;

   cdu_pulse_sched #(.NCH(NCH), .CNT_W(CNT_W), .GAP(GAP)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_plus  (req_plus),
      .req_minus (req_minus),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_ch    (out_ch),
      .out_minus (out_minus),
      .ovf       (ovf)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: counts as plain integers, offer timing from "last acceptance + gap".
   int             p_m [NCH];
   bit             m_vld;
   int             m_ch;
   bit             m_minus;
   int             rr_m;
   int             last_acc;
   int             cyc = 0;
   logic [NCH-1:0] m_ovf;

   int acc_ch[$];
   bit acc_minus[$];
   int acc_cyc[$];

   function automatic void model_reset();
      for (int i = 0; i < NCH; i++) p_m[i] = 0;
      m_vld    = 1'b0;
      m_ch     = 0;
      m_minus  = 1'b0;
      rr_m     = 0;
      last_acc = -100;
      m_ovf    = '0;
   endfunction

   function automatic void model_edge(input logic [NCH-1:0] pl, input logic [NCH-1:0] mi,
                                      input logic rdy, input logic r);
      int old_p [NCH];
      bit acc;
      int spacing;
      spacing = (GAP > 0) ? GAP : 1;
      if (r) begin
         model_reset();
      end else begin
         old_p = p_m;
         acc   = m_vld && rdy;
         for (int i = 0; i < NCH; i++) begin
            int raw;
            raw = p_m[i] + int'(pl[i]) - int'(mi[i]);
            if (acc && m_ch == i) raw = raw + (m_minus ? 1 : -1);
            if (raw > PMAX) begin
               raw = PMAX;
               if (OVF_EN) m_ovf[i] = 1'b1;
            end else if (raw < PMIN) begin
               raw = PMIN;
               if (OVF_EN) m_ovf[i] = 1'b1;
            end
            p_m[i] = raw;
         end
         if (acc) begin
            m_vld    = 1'b0;
            last_acc = cyc;
            rr_m     = (m_ch + 1) % NCH;
         end else if (!m_vld && cyc >= last_acc + spacing) begin
            for (int k = 0; k < NCH; k++) begin
               int c;
               c = (rr_m + k) % NCH;
               if (old_p[c] != 0) begin
                  m_vld   = 1'b1;
                  m_ch    = c;
                  m_minus = (old_p[c] < 0);
                  break;
               end
            end
         end
      end
      cyc++;
   endfunction

   function automatic logic [9:0] got_vec();
      return {out_valid, out_valid ? out_ch : 3'b000, out_valid & out_minus, ovf};
   endfunction

   function automatic logic [9:0] exp_vec();
      return {m_vld, m_vld ? 3'(m_ch) : 3'b000, m_vld & m_minus, m_ovf};
   endfunction

   task automatic cycle(input logic [NCH-1:0] pl, input logic [NCH-1:0] mi,
                        input logic rdy, input logic r);
      req_plus  = pl;
      req_minus = mi;
      out_ready = rdy;
      rst       = r;
      if (!r && out_valid && rdy) begin
         acc_ch.push_back(int'(out_ch));
         acc_minus.push_back(out_minus);
         acc_cyc.push_back(cyc);
      end
      @(posedge clk);
      model_edge(pl, mi, rdy, r);
      #1;
   endtask

   task automatic apply_reset();
      cycle('0, '0, 1'b0, 1'b1);
      cycle('0, '0, 1'b0, 1'b1);
      acc_ch.delete();
      acc_minus.delete();
      acc_cyc.delete();
   endtask

   task automatic test_reset();
      for (int n = 0; n < 4; n++) begin
         cycle(NCH'($urandom), NCH'($urandom), 1'($urandom), 1'b1);
         n_cmp++;
         if ({out_valid, out_ch, out_minus, ovf} !== 10'd0) begin
            n_bad++;
            $display("FAIL reset_outputs cyc=%0d got=%h exp=000", cyc, {out_valid, out_ch, out_minus, ovf});
         end
      end
      cycle('0, '0, 1'b1, 1'b0);
      n_cmp++;
      if (got_vec() !== exp_vec()) begin
         n_bad++;
         $display("FAIL reset_release cyc=%0d got=%h exp=%h", cyc, got_vec(), exp_vec());
      end
   endtask

   task automatic test_single();
      int s;
      apply_reset();
      s = cyc;
      cycle(5'b00100, '0, 1'b1, 1'b0);
      for (int n = 0; n < 9; n++) begin
         n_cmp++;
         if (got_vec() !== exp_vec()) begin
            n_bad++;
            $display("FAIL single cyc=%0d got=%h exp=%h", cyc, got_vec(), exp_vec());
         end
         cycle('0, '0, 1'b1, 1'b0);
      end
      n_cmp++;
      if (acc_ch.size() != 1 || acc_ch[0] != 2 || acc_minus[0] != 1'b0 || acc_cyc[0] != s + 2) begin
         n_bad++;
         $display("FAIL single_pulse got n=%0d first=(ch%0d m%0d @%0d) exp n=1 (ch2 m0 @%0d)",
                  acc_ch.size(), (acc_ch.size() > 0) ? acc_ch[0] : -1,
                  (acc_ch.size() > 0) ? acc_minus[0] : 0, (acc_ch.size() > 0) ? acc_cyc[0] : -1, s + 2);
      end
   endtask

   task automatic test_two_ch();
      int s;
      apply_reset();
      s = cyc;
      cycle(5'b10000, 5'b00001, 1'b1, 1'b0);
      for (int n = 0; n < 12; n++) begin
         n_cmp++;
         if (got_vec() !== exp_vec()) begin
            n_bad++;
            $display("FAIL two_ch cyc=%0d got=%h exp=%h", cyc, got_vec(), exp_vec());
         end
         cycle('0, '0, 1'b1, 1'b0);
      end
      n_cmp++;
      if (acc_ch.size() != 2 || acc_ch[0] != 0 || acc_minus[0] != 1'b1 || acc_cyc[0] != s + 2
          || acc_ch[1] != 4 || acc_minus[1] != 1'b0 || acc_cyc[1] != s + 6) begin
         n_bad++;
         $display("FAIL two_ch_order got n=%0d exp n=2 ch0-minus @%0d then ch4-plus @%0d",
                  acc_ch.size(), s + 2, s + 6);
      end
   endtask

   task automatic test_saturate();
      int n_plus;
      apply_reset();
      for (int n = 0; n < 9; n++) begin
         cycle(5'b00010, '0, 1'b0, 1'b0);
         n_cmp++;
         if (got_vec() !== exp_vec()) begin
            n_bad++;
            $display("FAIL saturate_fill cyc=%0d got=%h exp=%h", cyc, got_vec(), exp_vec());
         end
      end
      n_cmp++;
      if (ovf[1] !== OVF_EN) begin
         n_bad++;
         $display("FAIL saturate_ovf got=%b exp=%b", ovf[1], OVF_EN);
      end
      for (int n = 0; n < 40; n++) begin
         cycle('0, '0, 1'b1, 1'b0);
         n_cmp++;
         if (got_vec() !== exp_vec()) begin
            n_bad++;
            $display("FAIL saturate_drain cyc=%0d got=%h exp=%h", cyc, got_vec(), exp_vec());
         end
      end
      n_plus = 0;
      foreach (acc_ch[j]) if (acc_ch[j] == 1 && !acc_minus[j]) n_plus++;
      n_cmp++;
      if (n_plus != 7 || acc_ch.size() != 7) begin
         n_bad++;
         $display("FAIL saturate_count got=%0d (plus ch1 %0d) exp=7", acc_ch.size(), n_plus);
      end
   endtask

   task automatic test_stable();
      apply_reset();
      cycle(5'b01000, '0, 1'b0, 1'b0);
      cycle('0, '0, 1'b0, 1'b0);
      for (int n = 0; n < 3; n++) begin
         cycle('0, (n < 2) ? 5'b01000 : 5'b00000, 1'b0, 1'b0);
         n_cmp++;
         if (out_valid !== 1'b1 || out_ch !== 3'd3 || out_minus !== 1'b0) begin
            n_bad++;
            $display("FAIL stable_offer cyc=%0d got v=%b ch=%0d m=%b exp v=1 ch=3 m=0",
                     cyc, out_valid, out_ch, out_minus);
         end
      end
      for (int n = 0; n < 20; n++) begin
         cycle('0, '0, 1'b1, 1'b0);
         n_cmp++;
         if (got_vec() !== exp_vec()) begin
            n_bad++;
            $display("FAIL stable_drain cyc=%0d got=%h exp=%h", cyc, got_vec(), exp_vec());
         end
      end
      n_cmp++;
      if (acc_ch.size() != 3 || acc_minus[0] != 1'b0 || acc_minus[1] != 1'b1 || acc_minus[2] != 1'b1
          || acc_ch[0] != 3 || acc_ch[1] != 3 || acc_ch[2] != 3) begin
         n_bad++;
         $display("FAIL stable_seq got n=%0d exp ch3 plus, minus, minus", acc_ch.size());
      end
   endtask

   task automatic test_rst_hold();
      apply_reset();
      for (int n = 0; n < 6; n++) cycle(5'b00001, '0, 1'b0, 1'b0);
      cycle('0, '0, 1'b1, 1'b0);
      n_cmp++;
      if (got_vec() !== exp_vec() || out_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL rst_hold_pre cyc=%0d got=%h exp=%h", cyc, got_vec(), exp_vec());
      end
      cycle(5'b00001, '0, 1'b1, 1'b1);
      n_cmp++;
      if ({out_valid, out_ch, out_minus, ovf} !== 10'd0) begin
         n_bad++;
         $display("FAIL rst_hold_outputs got=%h exp=000", {out_valid, out_ch, out_minus, ovf});
      end
      acc_ch.delete();
      acc_minus.delete();
      acc_cyc.delete();
      for (int n = 0; n < 20; n++) begin
         cycle('0, '0, 1'b1, 1'b0);
         n_cmp++;
         if (got_vec() !== exp_vec()) begin
            n_bad++;
            $display("FAIL rst_hold_idle cyc=%0d got=%h exp=%h", cyc, got_vec(), exp_vec());
         end
      end
      n_cmp++;
      if (acc_ch.size() != 0) begin
         n_bad++;
         $display("FAIL rst_hold_pulses got=%0d exp=0", acc_ch.size());
      end
   endtask

   task automatic test_rr();
      int exp_order [10];
      int gap_bad;
      exp_order = '{0, 1, 2, 3, 4, 0, 1, 2, 3, 4};
      apply_reset();
      cycle('1, '0, 1'b0, 1'b0);
      cycle('1, '0, 1'b0, 1'b0);
      cycle('0, '0, 1'b0, 1'b0);
      for (int n = 0; n < 50; n++) begin
         cycle('0, '0, 1'b1, 1'b0);
         n_cmp++;
         if (got_vec() !== exp_vec()) begin
            n_bad++;
            $display("FAIL rr_cycle cyc=%0d got=%h exp=%h", cyc, got_vec(), exp_vec());
         end
      end
      n_cmp++;
      if (acc_ch.size() != 10) begin
         n_bad++;
         $display("FAIL rr_count got=%0d exp=10", acc_ch.size());
      end else begin
         gap_bad = 0;
         for (int j = 0; j < 10; j++) begin
            if (acc_ch[j] != exp_order[j] || acc_minus[j]) gap_bad++;
            if (j > 0 && acc_cyc[j] - acc_cyc[j-1] != GAP + 1) gap_bad++;
         end
         n_cmp++;
         if (gap_bad != 0) begin
            n_bad++;
            $display("FAIL rr_order_spacing got %0d deviations exp 0 (order 0..4,0..4 every 4 cycles)", gap_bad);
         end
      end
   endtask

   task automatic test_random();
      apply_reset();
      for (int n = 0; n < 700; n++) begin
         logic [NCH-1:0] pl, mi;
         pl = ($urandom_range(0, 2) == 0) ? NCH'($urandom) : '0;
         mi = ($urandom_range(0, 2) == 0) ? NCH'($urandom) : '0;
         cycle(pl, mi, ($urandom_range(0, 3) != 0), ($urandom_range(0, 149) == 0));
         n_cmp++;
         if (got_vec() !== exp_vec()) begin
            n_bad++;
            $display("FAIL random cyc=%0d got=%h exp=%h", cyc, got_vec(), exp_vec());
         end
      end
      for (int n = 0; n < 120; n++) begin
         cycle('0, '0, 1'b1, 1'b0);
         n_cmp++;
         if (got_vec() !== exp_vec()) begin
            n_bad++;
            $display("FAIL random_drain cyc=%0d got=%h exp=%h", cyc, got_vec(), exp_vec());
         end
      end
   endtask

   initial begin
      rst       = 1'b1;
      req_plus  = '0;
      req_minus = '0;
      out_ready = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      test_reset();
      test_single();
      test_two_ch();
      test_saturate();
      test_stable();
      test_rst_hold();
      test_rr();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
